// File: rtl/cpu_mul_pipeline_if.sv
// cpu_mul_pipeline_if
//   Groups the multiplier's issue, control, hazard-query and bank-write
//   signals into one bundle.
//   master : issue/decode side (drives issue_*, stall, flush, query_reg_*)
//   slave  : the multiplier (drives issue_ready, query_hit_*, write_*_mul,
//            in_flight)
//   Optional macro MUL_HIGH_EN adds issue_high (high-half product select).
interface cpu_mul_pipeline_if #(
  parameter int REG_WIDTH  = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_STAGES = 5
);
  localparam int CNT_W = $clog2(MUL_STAGES + 1);

  logic                  issue_valid;
  logic                  issue_ready;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic [REG_WIDTH-1:0]  issue_a;
  logic [REG_WIDTH-1:0]  issue_b;
`ifdef MUL_HIGH_EN
  logic                  issue_high;
`endif
  logic                  stall;
  logic                  flush;
  logic [REG_ADDR_W-1:0] query_reg_a;
  logic [REG_ADDR_W-1:0] query_reg_b;
  logic                  query_hit_a;
  logic                  query_hit_b;
  logic                  write_enable_mul;
  logic [REG_ADDR_W-1:0] write_reg_mul;
  logic [REG_WIDTH-1:0]  write_data_mul;
  logic [CNT_W-1:0]      in_flight;

  modport master (
`ifdef MUL_HIGH_EN
    output issue_high,
`endif
    output issue_valid, issue_rd, issue_a, issue_b, stall, flush,
           query_reg_a, query_reg_b,
    input  issue_ready, query_hit_a, query_hit_b, write_enable_mul,
           write_reg_mul, write_data_mul, in_flight
  );

  modport slave (
`ifdef MUL_HIGH_EN
    input  issue_high,
`endif
    input  issue_valid, issue_rd, issue_a, issue_b, stall, flush,
           query_reg_a, query_reg_b,
    output issue_ready, query_hit_a, query_hit_b, write_enable_mul,
           write_reg_mul, write_data_mul, in_flight
  );
endinterface

// File: rtl/cpu_mul_pipeline.sv
// cpu_mul_pipeline
//   Fixed-latency, in-order pipelined integer multiplier feeding the
//   register bank's multiply write port. An op accepted at the end of
//   cycle N writes in cycle N+MUL_STAGES (plus one cycle per stall cycle).
//   Result is the low REG_WIDTH bits of the unsigned product.
//   Ports:
//     clock, reset : rising-edge clock, asynchronous active-high reset
//     bus (slave)  : issue handshake, stall/flush, RAW hazard queries,
//                    bank write port and in-flight count
//   Optional macro MUL_HIGH_EN: per-op issue_high selects the upper
//   product half instead of the lower one; timing is unchanged.
module cpu_mul_pipeline #(
  parameter int REG_WIDTH  = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_STAGES = 5
) (
  input  logic clock,
  input  logic reset,
  cpu_mul_pipeline_if.slave bus
);
  localparam int LAST  = MUL_STAGES - 1;
  localparam int CNT_W = $clog2(MUL_STAGES + 1);

  // Control (reset) state
  logic [MUL_STAGES-1:0] vld_p;
  logic [MUL_STAGES-1:0] vld_nxt;
  logic [CNT_W-1:0]      in_flight_q;

  // Datapath state (never reset)
  logic [REG_ADDR_W-1:0] rd_p  [MUL_STAGES];
  logic [REG_WIDTH-1:0]  a_p0;
  logic [REG_WIDTH-1:0]  b_p0;
  logic                  high_p0;
  logic [REG_WIDTH-1:0]  res_p [1:LAST];

  logic accept;
  logic high_in;
  logic hit_a;
  logic hit_b;

  function automatic logic [REG_WIDTH-1:0] mul_select(
    input logic [REG_WIDTH-1:0] a,
    input logic [REG_WIDTH-1:0] b,
    input logic                 high
  );
    logic [2*REG_WIDTH-1:0] prod;
    prod = {{REG_WIDTH{1'b0}}, a} * {{REG_WIDTH{1'b0}}, b};
    return high ? prod[2*REG_WIDTH-1:REG_WIDTH] : prod[REG_WIDTH-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] count_valid(
    input logic [MUL_STAGES-1:0] v
  );
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MUL_STAGES; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

`ifdef MUL_HIGH_EN
  assign high_in = bus.issue_high;
`else
  assign high_in = 1'b0;
`endif

  assign bus.issue_ready = !bus.stall && !bus.flush;
  assign accept          = bus.issue_valid && bus.issue_ready;

  // Flush clears the post-edge valids of every stage but the last, so the
  // op that shifts into the last stage (or is held there) still commits.
  always_comb begin
    vld_nxt = vld_p;
    if (!bus.stall) begin
      vld_nxt[0] = accept;
      for (int i = 1; i < MUL_STAGES; i++) vld_nxt[i] = vld_p[i-1];
    end
    if (bus.flush) vld_nxt[LAST-1:0] = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p       <= '0;
      in_flight_q <= '0;
    end else begin
      vld_p       <= vld_nxt;
      in_flight_q <= count_valid(vld_nxt);
    end
  end

  always_ff @(posedge clock) begin
    if (!bus.stall) begin
      // Stage 0: capture operands
      a_p0     <= bus.issue_a;
      b_p0     <= bus.issue_b;
      high_p0  <= high_in;
      rd_p[0]  <= bus.issue_rd;
      // Stage 1: product formed
      res_p[1] <= mul_select(a_p0, b_p0, high_p0);
      rd_p[1]  <= rd_p[0];
      // Stages 2..LAST: result carried to the write port
      for (int i = 2; i < MUL_STAGES; i++) begin
        res_p[i] <= res_p[i-1];
        rd_p[i]  <= rd_p[i-1];
      end
    end
  end

  // The last stage still counts as a hit while writing: the bank write is
  // not readable until the following cycle.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < MUL_STAGES; i++) begin
      hit_a = hit_a | (vld_p[i] && (rd_p[i] == bus.query_reg_a));
      hit_b = hit_b | (vld_p[i] && (rd_p[i] == bus.query_reg_b));
    end
  end

  assign bus.query_hit_a      = hit_a;
  assign bus.query_hit_b      = hit_b;
  assign bus.write_enable_mul = vld_p[LAST] && !bus.stall;
  // Data regs are unreset, so force the bus to zero while reset is held.
  assign bus.write_reg_mul    = reset ? '0 : rd_p[LAST];
  assign bus.write_data_mul   = reset ? '0 : res_p[LAST];
  assign bus.in_flight        = in_flight_q;

endmodule

// File: tb/tb_cpu_mul_pipeline.sv
module tb_cpu_mul_pipeline;
  localparam int RW = 32;
  localparam int AW = 5;
  localparam int NS = 5;

  logic clock;
  logic reset;
  int   total;
  int   passed;

  cpu_mul_pipeline_if #(.REG_WIDTH(RW), .REG_ADDR_W(AW), .MUL_STAGES(NS)) bus ();

  cpu_mul_pipeline #(.REG_WIDTH(RW), .REG_ADDR_W(AW), .MUL_STAGES(NS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] rd, input logic [RW-1:0] a, input logic [RW-1:0] b);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = rd;
    bus.issue_a     = a;
    bus.issue_b     = b;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    reset  = 1'b0;
    idle();
    bus.issue_rd    = '0;
    bus.issue_a     = '0;
    bus.issue_b     = '0;
    bus.query_reg_a = '0;
    bus.query_reg_b = '0;
`ifdef MUL_HIGH_EN
    bus.issue_high  = 1'b0;
`endif

    // Reset state
    #2 reset = 1'b1;
    #20;
    check("rst_we",   bus.write_enable_mul, 0);
    check("rst_reg",  bus.write_reg_mul,    0);
    check("rst_data", bus.write_data_mul,   0);
    check("rst_hit",  bus.query_hit_a,      0);
    check("rst_infl", bus.in_flight,        0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Basic latency: 7*6 to r3, written in cycle 5 only
    for (int c = 0; c < 7; c++) begin
      if (c == 0) issue(5'd3, 32'd7, 32'd6); else idle();
      mid();
      if (c == 0) check("basic_ready", bus.issue_ready, 1);
      check($sformatf("basic_we_c%0d", c), bus.write_enable_mul, (c == 5));
      if (c == 5) begin
        check("basic_reg",  bus.write_reg_mul,  3);
        check("basic_data", bus.write_data_mul, 42);
      end
      adv();
    end

    // Wraparound: 0xFFFFFFFF * 2
    for (int c = 0; c < 6; c++) begin
      if (c == 0) begin
        issue(5'd7, 32'hFFFF_FFFF, 32'd2);
`ifdef MUL_HIGH_EN
        bus.issue_high = 1'b1;
`endif
      end else idle();
      mid();
      if (c == 5) begin
        check("wrap_we",  bus.write_enable_mul, 1);
        check("wrap_reg", bus.write_reg_mul,    7);
`ifdef MUL_HIGH_EN
        check("wrap_data_hi", bus.write_data_mul, 32'h0000_0001);
`else
        check("wrap_data", bus.write_data_mul, 32'hFFFF_FFFE);
`endif
      end
      adv();
    end
`ifdef MUL_HIGH_EN
    bus.issue_high = 1'b0;
`endif

    // Back-to-back: rd=i, a=b=i for i=1..5
    for (int c = 0; c < 11; c++) begin
      if (c < 5) issue(AW'(c + 1), RW'(c + 1), RW'(c + 1)); else idle();
      mid();
      check($sformatf("b2b_we_c%0d", c), bus.write_enable_mul, (c >= 5 && c <= 9));
      if (c >= 5 && c <= 9) begin
        check($sformatf("b2b_reg_c%0d", c),  bus.write_reg_mul,  c - 4);
        check($sformatf("b2b_data_c%0d", c), bus.write_data_mul, (c - 4) * (c - 4));
      end
      if (c == 5)  check("b2b_infl_full",  bus.in_flight, 5);
      if (c == 10) check("b2b_infl_empty", bus.in_flight, 0);
      adv();
    end

    // Stall in cycles 5..7 while the result sits in the last stage
    for (int c = 0; c < 10; c++) begin
      if (c == 0) issue(5'd2, 32'd3, 32'd5); else idle();
      bus.stall = (c >= 5 && c <= 7);
      mid();
      check($sformatf("stall_we_c%0d", c), bus.write_enable_mul, (c == 8));
      if (c >= 5 && c <= 7) check($sformatf("stall_ready_c%0d", c), bus.issue_ready, 0);
      if (c == 7) check("stall_infl", bus.in_flight, 1);
      if (c == 8) begin
        check("stall_reg",  bus.write_reg_mul,  2);
        check("stall_data", bus.write_data_mul, 15);
      end
      if (c == 9) check("stall_infl_end", bus.in_flight, 0);
      adv();
    end

    // Flush in cycle 4 with a concurrent (dropped) issue
    for (int c = 0; c < 12; c++) begin
      if (c <= 4) issue(AW'(c + 1), RW'(c + 1), 32'd10); else idle();
      bus.flush = (c == 4);
      mid();
      if (c == 4) check("flush_ready", bus.issue_ready, 0);
      check($sformatf("flush_we_c%0d", c), bus.write_enable_mul, (c == 5));
      if (c == 5) begin
        check("flush_reg",  bus.write_reg_mul,  1);
        check("flush_data", bus.write_data_mul, 10);
        check("flush_infl", bus.in_flight,      1);
      end
      if (c == 6) check("flush_infl_end", bus.in_flight, 0);
      adv();
    end

    // Hazard query on rd=9
    bus.query_reg_a = 5'd9;
    bus.query_reg_b = 5'd8;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) issue(5'd9, 32'd2, 32'd2); else idle();
      mid();
      check($sformatf("hit_a_c%0d", c), bus.query_hit_a, (c >= 1 && c <= 5));
      check($sformatf("hit_b_c%0d", c), bus.query_hit_b, 0);
      adv();
    end

    // Async reset mid-flight while the first op is writing
    for (int c = 0; c < 6; c++) begin
      if (c < 5) issue(5'd9, 32'd4, 32'd4); else idle();
      mid();
      if (c == 5) begin
        check("pre_rst_we",   bus.write_enable_mul, 1);
        check("pre_rst_hit",  bus.query_hit_a,      1);
        check("pre_rst_infl", bus.in_flight,        5);
        #1 reset = 1'b1;
        #1;
        check("arst_we",   bus.write_enable_mul, 0);
        check("arst_hit",  bus.query_hit_a,      0);
        check("arst_infl", bus.in_flight,        0);
        check("arst_reg",  bus.write_reg_mul,    0);
        check("arst_data", bus.write_data_mul,   0);
      end
      adv();
    end
    reset = 1'b0;
    idle();
    for (int c = 0; c < 6; c++) begin
      mid();
      check($sformatf("post_rst_we_c%0d", c), bus.write_enable_mul, 0);
      adv();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cpu_mul_pipeline.md
Name: cpu_mul_pipeline

Overview:
- Fixed-latency, in-order pipelined integer multiplier.
- Sits between issue/decode and the register bank's second (multiply) write port.
- Drives write_enable_mul / write_reg_mul / write_data_mul straight into the bank, which also forwards them to the forwarding unit.
- Reports in-flight destination registers so decode can stall RAW hazards on not-yet-written products.

Parameters:
- REG_WIDTH, 32, operand/result width.
- REG_ADDR_W, 5, register index width (32 registers; reg 0 is an ordinary writable register).
- MUL_STAGES, 5, pipeline depth, legal range 2..8.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- issue_valid  in  1  multiply op presented this cycle
- issue_ready  out  1  op accepted at this edge when high with issue_valid
- issue_rd  in  REG_ADDR_W  destination register
- issue_a  in  REG_WIDTH  operand A
- issue_b  in  REG_WIDTH  operand B
- stall  in  1  global pipeline hold
- flush  in  1  squash speculative in-flight ops
- query_reg_a  in  REG_ADDR_W  decode source register A
- query_reg_b  in  REG_ADDR_W  decode source register B
- query_hit_a  out  1  query_reg_a matches a valid in-flight rd
- query_hit_b  out  1  query_reg_b matches a valid in-flight rd
- write_enable_mul  out  1  write strobe to bank multiply port
- write_reg_mul  out  REG_ADDR_W  destination register
- write_data_mul  out  REG_WIDTH  product
- in_flight  out  $clog2(MUL_STAGES+1)  count of valid stages

Behaviour:
- Stages s[0..MUL_STAGES-1]. Each stage holds valid, rd, and partial/final product.
- Reset (async): all valids and in_flight go to 0 immediately. write_enable_mul=0, write_reg_mul=0, write_data_mul=0, query_hit_*=0.
  - Stage data may stay uninitialised, but outputs must read 0 while reset is asserted.
- issue_ready = !stall && !flush (combinational).
- Accept at a rising edge when issue_valid && issue_ready: s[0] loads valid=1, rd, operands.
- No accept: s[0].valid <= 0 unless stalled.
- Advance: when !stall, every edge shifts s[i] -> s[i+1].
- Latency: an op accepted at the end of cycle N drives write_enable_mul=1 for exactly one cycle, N+MUL_STAGES, when no stall intervenes.
  - Each stall cycle adds one cycle of latency.
- Result: low REG_WIDTH bits of the unsigned 2*REG_WIDTH product. This equals the signed low half.
- Outputs come from s[MUL_STAGES-1], gated:
  - write_enable_mul = s[last].valid && !stall
  - write_reg_mul and write_data_mul are always driven from s[last].
- Stall: all stages hold, and write_enable_mul is forced 0. A held result writes exactly once, in the first cycle stall is low, then leaves at that edge.
- Flush (priority over stall and issue): at the edge, clears valid of s[0]..s[MUL_STAGES-2].
  - s[last] is architecturally committed. When !stall it writes this cycle and leaves normally; when stall=1 it holds and writes once stall drops.
  - A concurrent issue is dropped, since issue_ready=0.
- query_hit_x: combinational OR over all stages of (valid && rd==query_reg_x).
  - Includes s[last] even while it is writing this cycle, because the bank write is not visible to reads until the next cycle.
- Same rd may be in flight multiple times. Order is preserved, so the youngest writes last.
- in_flight: registered count equal to the number of valid stages after each edge.
  - Increments on accept, decrements on retire, unchanged when both happen.
  - Flush sets it to the post-flush valid count.
  - Never exceeds MUL_STAGES.

Optional Feature:
- Macro: MUL_HIGH_EN.
- Defined: adds input issue_high (1 bit), carried per stage.
  - issue_high=1 selects product bits [2*REG_WIDTH-1:REG_WIDTH], unsigned.
  - issue_high=0 selects the low half.
- Undefined: port absent, low half only. Timing is identical in both builds.

Test Plan:
- Basic latency: reset released; issue a=7, b=6, rd=3 in cycle 0 -> write_enable_mul=1, write_reg_mul=3, write_data_mul=42 in cycle 5 only.
- Wrap: a=0xFFFFFFFF, b=2 -> data 0xFFFFFFFE.
  - With MUL_HIGH_EN and issue_high=1 -> data 0x00000001.
- Back-to-back: 5 consecutive issues rd=1..5, a=i, b=i -> writes in cycles 5..9 with data 1, 4, 9, 16, 25.
  - in_flight reaches 5 and returns to 0 by cycle 10.
- Stall: stall=1 for cycles 5..7 while the first result sits in the last stage -> no write in 5..7; single write in cycle 8.
  - issue_ready=0 during the stall.
- Flush: issue rd=1..4 in cycles 0..3; flush in cycle 4 -> only the rd=1 result writes (cycle 5).
  - Cycle-4 issue dropped; in_flight=0 after cycle 5.
- Hazard/reset: issue rd=9; query_reg_a=9 -> query_hit_a=1 in cycles 1..5, 0 in cycle 6.
  - Async reset asserted mid-flight -> hits, write_enable_mul and in_flight go to 0 before the next edge.
